cfg_col_sequencer: RTL and testbench

Upstream feeder of the configuration-word shift register. Holds one LEN-bit configuration word per sensor column in a host-written register bank. On start, it walks columns 0..N_COLS-1, presenting each word with a one-cycle load pulse and waiting for the shifter's ready flag before advancing. Owns the sensor configuration enable and the column index, reports done/error to the scan controller, and guards the handshake with a timeout.

---
 rtl/cfg_col_sequencer_pkg.sv | 27 ++
 rtl/cfg_col_sequencer_if.sv | 35 +++
 rtl/cfg_word_bank.sv | 40 ++++
 rtl/cfg_col_sequencer.sv | 122 ++++++++++++
 tb/tb_cfg_col_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_col_sequencer_pkg.sv
// Shared definitions for the configuration-word path: default geometry and
// the sequencer state encoding used by the shifter and scan top as well.
package cfg_col_sequencer_pkg;

  localparam int CFG_LEN     = 7;
  localparam int CFG_N_COLS  = 24;
  localparam int CFG_TIMEOUT = 64;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SETUP = 4'd1,
    ST_LOAD  = 4'd2,
    ST_GUARD = 4'd3,
    ST_WAIT  = 4'd4,
    ST_NEXT  = 4'd5,
    ST_HOLD  = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } seq_state_t;

  // The sensor stays configured from SETUP through HOLD inclusive.
  function automatic logic sensor_en_state(input seq_state_t s);
    return (s == ST_SETUP) || (s == ST_LOAD) || (s == ST_GUARD) ||
           (s == ST_WAIT)  || (s == ST_NEXT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/cfg_col_sequencer_if.sv
// Host bank-write, scan-control and shifter handshake signals of the column
// sequencer; master is the sequencer side, slave is its environment.
interface cfg_col_sequencer_if
  import cfg_col_sequencer_pkg::*;
#(
  parameter int LEN    = CFG_LEN,
  parameter int N_COLS = CFG_N_COLS
);
  localparam int ADDR_W = $clog2(N_COLS);

  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [LEN-1:0]    i_wr_data;
  logic              i_start;
  logic              i_abort;
  logic              i_ready;
  logic              o_load;
  logic [LEN-1:0]    o_data;
  logic [ADDR_W-1:0] o_col_sel;
  logic              o_sensor_en;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  modport master (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_abort, i_ready,
    output o_load, o_data, o_col_sel, o_sensor_en, o_busy, o_done, o_error
  );

  modport slave (
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_abort, i_ready,
    input  o_load, o_data, o_col_sel, o_sensor_en, o_busy, o_done, o_error
  );

endinterface

// File: rtl/cfg_word_bank.sv
// Per-column configuration word register file: synchronous-reset write port,
// asynchronous read so the word is ready in the same cycle as the load pulse.
module cfg_word_bank
  import cfg_col_sequencer_pkg::*;
#(
  parameter int  LEN    = CFG_LEN,
  parameter int  N_COLS = CFG_N_COLS,
  localparam int ADDR_W = $clog2(N_COLS)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN-1:0]    wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LEN-1:0]    rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COLS - 1);

  logic [LEN-1:0] words [N_COLS];

  // Addresses at or beyond N_COLS match no word, so such writes vanish.
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_word
    logic [LEN-1:0] word_reg;

    always_ff @(posedge clk) begin
      if (!i_rst_n) begin
        word_reg <= '0;
      end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign words[gi] = word_reg;
  end

  assign rd_data = (rd_addr <= LAST_ADDR) ? words[rd_addr] : '0;

endmodule

// File: rtl/cfg_col_sequencer.sv
// Walks the column word bank, handing one word per column to the shifter
// with a load pulse and a ready handshake guarded by a timeout.
module cfg_col_sequencer
  import cfg_col_sequencer_pkg::*;
#(
  parameter int LEN     = CFG_LEN,
  parameter int N_COLS  = CFG_N_COLS,
  parameter int TIMEOUT = CFG_TIMEOUT
) (
  input  logic                clk,
  input  logic                i_rst_n,
  cfg_col_sequencer_if.master bus
);

  localparam int ADDR_W = $clog2(N_COLS);
  localparam int TW     = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(N_COLS - 1);
  localparam logic [TW-1:0]     TIMER_END = TW'(TIMEOUT - 1);

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] col_reg, col_next;
  logic [TW-1:0]     timer_reg, timer_next, timer_inc;
  logic              error_reg, error_next;
  logic              bank_wr_en;
  logic [LEN-1:0]    bank_rd_data;

  assign bank_wr_en = bus.i_wr_en && (state_reg == ST_IDLE);

  cfg_word_bank #(
    .LEN    (LEN),
    .N_COLS (N_COLS)
  ) u_bank (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .wr_en   (bank_wr_en),
    .wr_addr (bus.i_wr_addr),
    .wr_data (bus.i_wr_data),
    .rd_addr (col_reg),
    .rd_data (bank_rd_data)
  );

  // The timer runs from the load onward (GUARD included) and saturates.
  assign timer_inc = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      timer_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      timer_reg <= timer_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    timer_next = timer_reg;
    error_next = error_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_next = ST_SETUP;
          col_next   = '0;
          error_next = 1'b0;
        end
      end
      ST_SETUP: state_next = ST_LOAD;
      ST_LOAD: begin
        state_next = ST_GUARD;
        timer_next = '0;
      end
      // Shifter ready is not trustworthy in the cycle right after a load.
      ST_GUARD: begin
        state_next = ST_WAIT;
        timer_next = timer_inc;
      end
      ST_WAIT: begin
        if (bus.i_ready) begin
          state_next = ST_NEXT;
        end else if (timer_reg == TIMER_END) begin
          state_next = ST_ERR;
          error_next = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_NEXT: begin
        if (col_reg == LAST_COL) begin
          state_next = ST_HOLD;
        end else begin
          state_next = ST_LOAD;
          col_next   = col_reg + 1'b1;
        end
      end
      ST_HOLD: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Abort freezes column, timer and error flag; only the state drops back.
    if ((state_reg != ST_IDLE) && bus.i_abort) begin
      state_next = ST_IDLE;
      col_next   = col_reg;
      timer_next = timer_reg;
      error_next = error_reg;
    end
  end

  assign bus.o_load      = (state_reg == ST_LOAD);
  assign bus.o_data      = (state_reg == ST_LOAD) ? bank_rd_data : '0;
  assign bus.o_col_sel   = col_reg;
  assign bus.o_sensor_en = sensor_en_state(state_reg);
  assign bus.o_busy      = (state_reg != ST_IDLE);
  assign bus.o_done      = (state_reg == ST_DONE);
  assign bus.o_error     = error_reg;

endmodule

// File: tb/tb_cfg_col_sequencer.sv
// Scoreboard bench for cfg_col_sequencer: passes are predicted from a bank
// model and a shifter delay table, a monitor checks every load/done/error.
module tb_cfg_col_sequencer;
  import cfg_col_sequencer_pkg::*;

  localparam int LEN     = CFG_LEN;
  localparam int N_COLS  = CFG_N_COLS;
  localparam int TIMEOUT = CFG_TIMEOUT;
  localparam int ADDR_W  = $clog2(N_COLS);
  localparam int BOUND   = 3000;

  typedef enum int {EV_LOAD, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       col;
    int       data;
    int       gap;    // cycles since the previous event, -1 = not checked
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_col_sequencer_if #(.LEN(LEN), .N_COLS(N_COLS)) bus ();

  cfg_col_sequencer #(.LEN(LEN), .N_COLS(N_COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];
  int  bank_m[N_COLS];
  int  delay_tab[N_COLS];
  bit  stuck = 1'b0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Shifter busy time as seen by the handshake: ready is ignored for the
  // first two cycles after a load, so short delays cost two cycles anyway.
  function automatic int busy_cycles(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic push_pass(input int last_col, input bit with_done);
    ev_t e;
    for (int c = 0; c <= last_col; c++) begin
      e.kind = EV_LOAD;
      e.col  = c;
      e.data = bank_m[c];
      e.gap  = (c == 0) ? -1 : busy_cycles(delay_tab[c-1]) + 2;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.kind = EV_DONE;
      e.col  = 0;
      e.data = 0;
      e.gap  = busy_cycles(delay_tab[last_col]) + 3;
      exp_q.push_back(e);
    end
  endtask

  // Shifter model: ready drops at each load and returns delay_tab[col] later.
  initial begin
    int cnt;
    cnt = 0;
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_load) begin
        bus.i_ready = 1'b0;
        cnt = stuck ? -1 : delay_tab[int'(bus.o_col_sel)];
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.i_ready = 1'b1;
      end
    end
  end

  task automatic observe(input ev_kind_t k, input int col, input int data, input int gap);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", int'(k), -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      if (k == EV_LOAD && e.kind == EV_LOAD) begin
        check("load_col", col, e.col);
        check("load_data", data, e.data);
      end
      if (e.gap >= 0) check("event_gap", gap, e.gap);
    end
  endtask

  // Monitor
  initial begin
    int cyc, last;
    bit prev_err;
    cyc = 0;
    last = 0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_err = 1'b0;
      end else begin
        if (bus.o_load) begin
          $display("[%0d] load col=%0d data=0x%02h", cyc, bus.o_col_sel, bus.o_data);
          check("sensor_en_at_load", int'(bus.o_sensor_en), 1);
          observe(EV_LOAD, int'(bus.o_col_sel), int'(bus.o_data), cyc - last);
          last = cyc;
        end
        if (bus.o_done) begin
          $display("[%0d] done", cyc);
          check("sensor_en_at_done", int'(bus.o_sensor_en), 0);
          observe(EV_DONE, 0, 0, cyc - last);
          last = cyc;
        end
        if (bus.o_error && !prev_err) begin
          $display("[%0d] error", cyc);
          observe(EV_ERR, 0, 0, cyc - last);
          last = cyc;
        end
        prev_err = bus.o_error;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input int addr, input int data, input bit accepted);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = ADDR_W'(addr);
    bus.i_wr_data = LEN'(data);
    @(negedge clk);
    bus.i_wr_en = 1'b0;
    if (accepted && addr < N_COLS) bank_m[addr] = data;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_load_col(input int c, input string what);
    for (int i = 0; i < BOUND; i++) begin
      if (bus.o_load && int'(bus.o_col_sel) == c) return;
      @(negedge clk);
    end
    check({what, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string what);
    for (int i = 0; i < BOUND; i++) begin
      if (bus.o_done) return;
      @(negedge clk);
    end
    check({what, "_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},      int'(bus.o_load), 0);
    check({tag, "_data"},      int'(bus.o_data), 0);
    check({tag, "_col_sel"},   int'(bus.o_col_sel), 0);
    check({tag, "_sensor_en"}, int'(bus.o_sensor_en), 0);
    check({tag, "_busy"},      int'(bus.o_busy), 0);
    check({tag, "_done"},      int'(bus.o_done), 0);
    check({tag, "_error"},     int'(bus.o_error), 0);
  endtask

  task automatic set_delays(input bit rnd);
    for (int c = 0; c < N_COLS; c++) delay_tab[c] = rnd ? int'($urandom_range(1, 20)) : 14;
  endtask

  // Stimulus
  initial begin
    bit seen;
    bus.i_wr_en = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    for (int c = 0; c < N_COLS; c++) bank_m[c] = 0;
    set_delays(1'b0);

    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Full pass over col ^ 0x2A; an out-of-range write must not disturb it.
    for (int c = 0; c < N_COLS; c++) host_write(c, c ^ 'h2A, 1'b1);
    host_write(26, 'h11, 1'b1);
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    check("setup_sensor_en", int'(bus.o_sensor_en), 1);
    check("setup_busy", int'(bus.o_busy), 1);
    wait_done("pass1");
    tick(1);
    check("idle_after_done_busy", int'(bus.o_busy), 0);

    // Shifter never answers: error after TIMEOUT cycles, then a start clears it.
    begin
      ev_t e;
      stuck = 1'b1;
      e.kind = EV_LOAD; e.col = 0; e.data = bank_m[0]; e.gap = -1;
      exp_q.push_back(e);
      e.kind = EV_ERR; e.col = 0; e.data = 0; e.gap = TIMEOUT + 1;
      exp_q.push_back(e);
    end
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      if (bus.o_error) seen = 1'b1;
      else tick(1);
    end
    check("error_raised", int'(seen), 1);
    check("err_state_busy", int'(bus.o_busy), 1);
    tick(1);
    check("after_err_busy", int'(bus.o_busy), 0);
    check("after_err_sensor_en", int'(bus.o_sensor_en), 0);
    tick(5);
    check("error_sticky", int'(bus.o_error), 1);
    stuck = 1'b0;
    set_delays(1'b1);
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    check("start_clears_error", int'(bus.o_error), 0);
    wait_done("after_err_pass");
    tick(2);

    // Abort while waiting at column 5, then restart with start+abort together.
    set_delays(1'b0);
    push_pass(5, 1'b0);
    start_pulse();
    wait_load_col(5, "abort_col5");
    tick(2);
    bus.i_abort = 1'b1;
    tick(1);
    bus.i_abort = 1'b0;
    check("abort_busy", int'(bus.o_busy), 0);
    check("abort_sensor_en", int'(bus.o_sensor_en), 0);
    check("abort_load", int'(bus.o_load), 0);
    tick(20);
    check("abort_queue_left", exp_q.size(), 0);
    check("abort_col_held", int'(bus.o_col_sel), 5);
    push_pass(N_COLS - 1, 1'b1);
    bus.i_abort = 1'b1;
    start_pulse();
    bus.i_abort = 1'b0;
    check("start_beats_abort", int'(bus.o_sensor_en), 1);
    check("restart_col", int'(bus.o_col_sel), 0);
    wait_done("restart_pass");
    tick(2);

    // Host write while busy is dropped; the same write after the pass lands.
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    wait_load_col(2, "busy_write");
    host_write(3, 'h55, 1'b0);
    wait_done("busy_write_pass");
    tick(1);
    host_write(3, 'h55, 1'b1);
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    wait_done("write_landed_pass");
    tick(2);

    // Start held high: back-to-back passes with one IDLE cycle between.
    push_pass(N_COLS - 1, 1'b1);
    push_pass(N_COLS - 1, 1'b1);
    bus.i_start = 1'b1;
    tick(1);
    wait_done("held1");
    tick(1);
    check("held_gap_idle", int'(bus.o_busy), 0);
    tick(1);
    check("held_restart_setup", int'(bus.o_sensor_en), 1);
    bus.i_start = 1'b0;
    wait_done("held2");
    tick(2);
    check("held_released_idle", int'(bus.o_busy), 0);

    // Random bank contents and random shifter delays.
    repeat (40) host_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), 1'b1);
    set_delays(1'b1);
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    wait_done("random_pass");
    tick(2);

    // Reset at column 10 clears outputs and the bank.
    set_delays(1'b0);
    push_pass(10, 1'b0);
    start_pulse();
    wait_load_col(10, "reset_col10");
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_all_zero("midpass_reset");
    rst_n = 1'b1;
    for (int c = 0; c < N_COLS; c++) bank_m[c] = 0;
    check("reset_queue_left", exp_q.size(), 0);
    tick(1);
    push_pass(N_COLS - 1, 1'b1);
    start_pulse();
    wait_done("post_reset_pass");
    tick(5);
    check("final_queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
